fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer sitting directly upstream of the program-counter register.
- Drives the PC register's load/increment controls and load value, and issues read requests to instruction memory at the current PC.
- Buffers one fetched instruction and hands it to decode over a valid/ready handshake.
- Handles branch redirects and halt.

Parameters:
- ADDR_WIDTH, 8, width of PC and memory address.
- INSTR_WIDTH, 16, width of an instruction word.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_value  in  ADDR_WIDTH  current PC (PC register output).
- pc_load  out  1  PC register load strobe.
- pc_incr  out  1  PC register increment strobe.
- pc_load_value  out  ADDR_WIDTH  value for PC load.
- mem_req  out  1  instruction memory read request.
- mem_addr  out  ADDR_WIDTH  read address.
- mem_ack  in  1  read data valid, single-cycle pulse.
- mem_rdata  in  INSTR_WIDTH  read data.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts instruction.
- instr  out  INSTR_WIDTH  buffered instruction.
- branch_valid  in  1  redirect request, one cycle.
- branch_target  in  ADDR_WIDTH  redirect address.
- halt  in  1  level; stop issuing fetches while high.

Behaviour:
- Reset: clk and rst are the only clock/reset. rst=1 asynchronously forces state IDLE and the instr register to 0. While rst=1, all outputs are 0.
- States: IDLE, REQ, VALID, HALTED.
- IDLE: one cycle after reset release. Goes to REQ, or to HALTED if halt=1.
- REQ:
  - mem_req=1, mem_addr=pc_value; both held stable until mem_ack.
  - On mem_ack: capture mem_rdata into instr, assert pc_incr combinationally in the same cycle, go VALID.
  - Result: instr_valid rises the cycle after the ack, and the PC has already advanced.
- VALID:
  - instr_valid=1 and instr stable until instr_ready.
  - On instr_ready: go HALTED if halt=1, else REQ. Throughput is one instruction per 2 cycles plus memory latency.
- HALTED: no requests. Leaves to REQ the cycle after halt=0.
- Branch (any non-reset state):
  - pc_load=1 and pc_load_value=branch_target in the same cycle (combinational).
  - pc_incr is forced 0 that cycle, so load has priority.
  - REQ with or without a same-cycle ack: fetched data discarded, stay/return REQ. The next request uses the new PC.
  - REQ without ack: the outstanding request is abandoned; the memory returns nothing further.
  - VALID: instr_valid drops next cycle, even if instr_ready is also high (the handshake is discarded). Go REQ.
  - HALTED: load performed, remain HALTED.
- pc_load_value is 0 when branch_valid=0.
- A reset mid-transaction abandons the request. mem_req deasserts immediately.

Optional Feature:
- Macro FETCH_CTRL_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. It increments each cycle with mem_req=1 and mem_ack=0, saturates at 16'hFFFF, and resets to 0 on rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg: state enum typedef (IDLE, REQ, VALID, HALTED) and the default width constants.
- Optional sub-module fetch_stall_counter (saturating 16-bit counter), instantiated only under the macro.
- Otherwise a single module; the PC register stays external.

Test Plan:
- Reset release, pc_value=8'h00, mem_ack 2 cycles after req with rdata=16'hA5A5:
  - mem_req high the 2nd cycle after rst falls.
  - pc_incr pulses in the ack cycle.
  - instr_valid=1 with instr=16'hA5A5 the next cycle.
- instr_ready held low 5 cycles: instr_valid and instr stable, mem_req=0. Ready high → mem_req next cycle with mem_addr = incremented PC.
- branch_valid, target 8'h3C, in the same cycle as mem_ack:
  - pc_load=1, pc_load_value=8'h3C, pc_incr=0.
  - No instr_valid.
  - Next mem_addr=8'h3C.
- Branch while in VALID with instr_ready=1: instr_valid drops, no double consume, refetch from target.
- halt=1 during VALID handshake: HALTED, no mem_req for 10 cycles. halt=0 → mem_req next cycle.
- rst asserted mid-REQ: mem_req, pc_incr, pc_load, instr_valid go 0 immediately. With the macro defined, 4 un-acked request cycles → stall_cnt=4, and rst clears it.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned ADDR_WIDTH_DEF  = 8;
    localparam int unsigned INSTR_WIDTH_DEF = 16;
    localparam int unsigned STALL_CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StValid,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/fetch_stall_counter.sv
// Saturating cycle counter for memory stall cycles (used under FETCH_CTRL_STALL_CNT_EN).
module fetch_stall_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives the external PC register, requests instruction memory,
// buffers one instruction for decode. FETCH_CTRL_STALL_CNT_EN adds a stall_cnt output.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  pc_value,
    output logic                   pc_load,
    output logic                   pc_incr,
    output logic [ADDR_WIDTH-1:0]  pc_load_value,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    input  logic                   branch_valid,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt
`ifdef FETCH_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]            stall_cnt
`endif
);

    fetch_state_e           state_q;
    logic                   mem_req_q;
    logic                   instr_valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (halt) begin
                        state_q <= StHalted;
                    end else begin
                        state_q   <= StReq;
                        mem_req_q <= 1'b1;
                    end
                end
                StReq: begin
                    // A branch discards any same-cycle data; the request restarts at the new PC.
                    if (!branch_valid && mem_ack) begin
                        instr_q       <= mem_rdata;
                        state_q       <= StValid;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                StValid: begin
                    if (branch_valid) begin
                        state_q       <= StReq;
                        instr_valid_q <= 1'b0;
                        mem_req_q     <= 1'b1;
                    end else if (instr_ready) begin
                        instr_valid_q <= 1'b0;
                        if (halt) begin
                            state_q <= StHalted;
                        end else begin
                            state_q   <= StReq;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                StHalted: begin
                    if (!halt) begin
                        state_q   <= StReq;
                        mem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the combinational strobes so every output is 0 while rst is high.
    assign pc_load       = branch_valid & ~rst;
    assign pc_load_value = pc_load ? branch_target : '0;
    assign pc_incr       = mem_req_q & mem_ack & ~branch_valid;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_req_q ? pc_value : '0;
    assign instr_valid   = instr_valid_q;
    assign instr         = instr_q;

`ifdef FETCH_CTRL_STALL_CNT_EN
    fetch_stall_counter #(
        .WIDTH(STALL_CNT_WIDTH)
    ) u_stall_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (mem_req_q & ~mem_ack),
        .count(stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl; stall_cnt checks enabled with FETCH_CTRL_STALL_CNT_EN.
module tb_fetch_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_value;
    logic          pc_load;
    logic          pc_incr;
    logic [AW-1:0] pc_load_value;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr;
    logic          branch_valid;
    logic [AW-1:0] branch_target;
    logic          halt;
`ifdef FETCH_CTRL_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [IW-1:0] exp_instr_q[$];

    fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_value     (pc_value),
        .pc_load      (pc_load),
        .pc_incr      (pc_incr),
        .pc_load_value(pc_load_value),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .branch_valid (branch_valid),
        .branch_target(branch_target),
        .halt         (halt)
`ifdef FETCH_CTRL_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External PC register that the DUT controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_value <= '0;
        end else if (pc_load) begin
            pc_value <= pc_load_value;
        end else if (pc_incr) begin
            pc_value <= pc_value + 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: pops expected request addresses on acks and instructions on handshakes.
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_req && mem_ack) begin
            if (exp_addr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_addr: unexpected ack at addr %0h, none expected", mem_addr);
            end else begin
                chk("ack_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
            end
        end
        if (rst === 1'b0 && instr_valid && instr_ready && !branch_valid) begin
            if (exp_instr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL consume: unexpected instr %0h consumed, none expected", instr);
            end else begin
                chk("consume", 32'(instr), 32'(exp_instr_q.pop_front()));
            end
        end
    end

    initial begin
        rst           = 1'b1;
        mem_ack       = 1'b0;
        mem_rdata     = '0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b1;
        branch_target = 8'h3C;
        halt          = 1'b0;
        #3;
        chk("rst_pc_load", 32'(pc_load), 0);
        chk("rst_pc_load_value", 32'(pc_load_value), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_instr_valid", 32'(instr_valid), 0);
        chk("rst_instr", 32'(instr), 0);
        branch_valid  = 1'b0;
        branch_target = '0;
        nxt();
        nxt();
        rst = 1'b0;

        // First fetch: IDLE cycle, then request, ack two cycles later.
        mid(); chk("idle_no_req", 32'(mem_req), 0);
        nxt(); mid(); chk("req_rise", 32'(mem_req), 1); chk("req_addr0", 32'(mem_addr), 0);
        nxt(); mid(); chk("req_hold", 32'(mem_req), 1);
        nxt();
        mem_ack = 1'b1; mem_rdata = 16'hA5A5;
        exp_addr_q.push_back(8'h00); exp_instr_q.push_back(16'hA5A5);
        mid(); chk("ack_incr", 32'(pc_incr), 1); chk("ack_no_load", 32'(pc_load), 0);
        chk("ack_no_valid_yet", 32'(instr_valid), 0);
        nxt();
        mem_ack = 1'b0; mem_rdata = '0;
        mid(); chk("valid_rise", 32'(instr_valid), 1); chk("valid_instr", 32'(instr), 16'hA5A5);
        chk("valid_no_req", 32'(mem_req), 0);

        // Back-pressure: decode not ready for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            nxt(); mid();
            chk("stall_valid", 32'(instr_valid), 1);
            chk("stall_instr", 32'(instr), 16'hA5A5);
            chk("stall_no_req", 32'(mem_req), 0);
        end
        nxt(); instr_ready = 1'b1; mid();
        nxt(); instr_ready = 1'b0;
        mid(); chk("refetch_req", 32'(mem_req), 1); chk("refetch_addr", 32'(mem_addr), 8'h01);

        // Branch in the same cycle as the ack: data discarded, refetch from target.
        nxt();
        mem_ack = 1'b1; mem_rdata = 16'h1234; branch_valid = 1'b1; branch_target = 8'h3C;
        exp_addr_q.push_back(8'h01);
        mid(); chk("br_ack_load", 32'(pc_load), 1); chk("br_ack_value", 32'(pc_load_value), 8'h3C);
        chk("br_ack_no_incr", 32'(pc_incr), 0);
        nxt();
        mem_ack = 1'b0; branch_valid = 1'b0; branch_target = '0;
        mid(); chk("br_ack_no_valid", 32'(instr_valid), 0); chk("br_ack_req", 32'(mem_req), 1);
        chk("br_ack_addr", 32'(mem_addr), 8'h3C);
        chk("idle_load_value", 32'(pc_load_value), 0);

        // Branch in VALID while decode is ready: handshake discarded.
        nxt();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        exp_addr_q.push_back(8'h3C);
        mid(); chk("ack2_incr", 32'(pc_incr), 1);
        nxt(); mem_ack = 1'b0;
        mid(); chk("valid2", 32'(instr_valid), 1); chk("valid2_instr", 32'(instr), 16'hBEEF);
        nxt(); branch_valid = 1'b1; branch_target = 8'h50; instr_ready = 1'b1;
        mid(); chk("br_valid_load", 32'(pc_load), 1); chk("br_valid_no_incr", 32'(pc_incr), 0);
        nxt(); branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
        mid(); chk("br_valid_drop", 32'(instr_valid), 0); chk("br_valid_req", 32'(mem_req), 1);
        chk("br_valid_addr", 32'(mem_addr), 8'h50);

        // Halt during the VALID handshake, branch while halted.
        nxt();
        mem_ack = 1'b1; mem_rdata = 16'h0F0F;
        exp_addr_q.push_back(8'h50); exp_instr_q.push_back(16'h0F0F);
        mid(); chk("ack3_incr", 32'(pc_incr), 1);
        nxt(); mem_ack = 1'b0;
        mid(); chk("valid3", 32'(instr_valid), 1);
        nxt(); instr_ready = 1'b1; halt = 1'b1; mid();
        nxt(); instr_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                branch_valid = 1'b1; branch_target = 8'h70;
            end
            mid();
            chk("halt_no_req", 32'(mem_req), 0);
            chk("halt_no_valid", 32'(instr_valid), 0);
            if (i == 4) chk("halt_br_load", 32'(pc_load), 1);
            nxt();
            branch_valid = 1'b0; branch_target = '0;
        end
        halt = 1'b0;
        mid(); chk("unhalt_still_idle", 32'(mem_req), 0);
        nxt(); mid(); chk("unhalt_req", 32'(mem_req), 1); chk("unhalt_addr", 32'(mem_addr), 8'h70);

        // Asynchronous reset mid-request.
        nxt();
        mem_ack = 1'b1;
        #1; chk("pre_rst_incr", 32'(pc_incr), 1);
        #1; rst = 1'b1; branch_valid = 1'b1; branch_target = 8'h11;
        #1;
        chk("rst_async_req", 32'(mem_req), 0);
        chk("rst_async_incr", 32'(pc_incr), 0);
        chk("rst_async_load", 32'(pc_load), 0);
        chk("rst_async_valid", 32'(instr_valid), 0);
        chk("rst_async_instr", 32'(instr), 0);
        mem_ack = 1'b0; branch_valid = 1'b0; branch_target = '0;
`ifdef FETCH_CTRL_STALL_CNT_EN
        chk("stall_rst", 32'(stall_cnt), 0);
`endif
        nxt(); nxt();
        rst = 1'b0;
        mid();
        nxt();
        for (int i = 0; i < 4; i++) begin
            mid(); chk("unacked_req", 32'(mem_req), 1);
            nxt();
        end
        mid(); chk("post_rst_addr", 32'(mem_addr), 0);
`ifdef FETCH_CTRL_STALL_CNT_EN
        chk("stall_four", 32'(stall_cnt), 4);
        #1; rst = 1'b1; #1;
        chk("stall_cleared", 32'(stall_cnt), 0);
`endif

        chk("addr_queue_empty", 32'(exp_addr_q.size()), 0);
        chk("instr_queue_empty", 32'(exp_instr_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
